// File: rtl/power_pkg.sv
// power_pkg: mode encodings shared by power_mode_controller and ClockScaler,
// plus the one-level step-down helper used by the mode FSM.
package power_pkg;

  typedef enum logic [1:0] {
    MODE_QUARTER = 2'b00,
    MODE_HALF    = 2'b01,
    MODE_FULL    = 2'b10
  } power_mode_e;

  // One level slower; QUARTER is the floor.
  function automatic power_mode_e step_down(input power_mode_e m);
    case (m)
      MODE_FULL: return MODE_HALF;
      MODE_HALF: return MODE_QUARTER;
      default:   return MODE_QUARTER;
    endcase
  endfunction

endpackage

// File: rtl/power_mode_controller_if.sv
// power_mode_controller_if: activity/mode signals between the controller and its
// environment.
//   Alu_Valid   : activity sample (master -> slave)
//   Force_Full  : immediate full-speed request (master -> slave)
//   Power_Mode  : registered mode, 2'b00 /4, 2'b01 /2, 2'b10 full (slave -> master)
//   Mode_Change : one-cycle pulse when Power_Mode changes (slave -> master)
interface power_mode_controller_if;
  logic       Alu_Valid;
  logic       Force_Full;
  logic [1:0] Power_Mode;
  logic       Mode_Change;

  modport master (output Alu_Valid, Force_Full, input Power_Mode, Mode_Change);
  modport slave  (input Alu_Valid, Force_Full, output Power_Mode, Mode_Change);
endinterface

// File: rtl/activity_window_counter.sv
// activity_window_counter: splits time into WINDOW-cycle windows and counts
// activity samples inside each one.
//   Clk, Rst   : clock, asynchronous active-high reset
//   alu_valid  : activity sample for this cycle
//   window_end : high in the last cycle of every window
//   act_total  : activity count including this cycle's sample (valid at window_end)
module activity_window_counter #(
  parameter int unsigned WINDOW = 16
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             alu_valid,
  output logic                             window_end,
  output logic [$clog2(WINDOW+1)-1:0]      act_total
);

  localparam int unsigned WIN_W = $clog2(WINDOW);
  localparam int unsigned ACT_W = $clog2(WINDOW + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [ACT_W-1:0] act_cnt;

  assign window_end = (win_cnt == WIN_W'(WINDOW - 1));
  // act_cnt is at most WINDOW-1 at window end, so adding the last sample fits.
  assign act_total  = act_cnt + ACT_W'(alu_valid);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      win_cnt <= '0;
      act_cnt <= '0;
    end else if (window_end) begin
      win_cnt <= '0;
      act_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (alu_valid && (act_cnt != ACT_W'(WINDOW)))
        act_cnt <= act_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/power_mode_controller.sv
// power_mode_controller: picks a clock-scaling mode from ALU activity measured
// over fixed windows. High activity jumps to full speed, a run of low windows
// steps down one level, Force_Full overrides everything.
//   Clk, Rst : clock, asynchronous active-high reset
//   bus      : slave side of power_mode_controller_if
//              (Alu_Valid, Force_Full in; Power_Mode, Mode_Change out)
module power_mode_controller
  import power_pkg::*;
#(
  parameter int unsigned WINDOW       = 16,
  parameter int unsigned HI_THRESH    = 12,
  parameter int unsigned LO_THRESH    = 4,
  parameter int unsigned DOWN_WINDOWS = 2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  power_mode_controller_if.slave bus
);

  generate
    if (!(LO_THRESH <= HI_THRESH && HI_THRESH <= WINDOW && DOWN_WINDOWS >= 1 && WINDOW >= 4))
    begin : g_bad_params
      $error("power_mode_controller: illegal parameter set");
    end
  endgenerate

  localparam int unsigned ACT_W    = $clog2(WINDOW + 1);
  localparam int unsigned STREAK_W = $clog2(DOWN_WINDOWS + 1);
  localparam logic [ACT_W-1:0]    HI_T = ACT_W'(HI_THRESH);
  localparam logic [ACT_W-1:0]    LO_T = ACT_W'(LO_THRESH);
  localparam logic [STREAK_W-1:0] DW_T = STREAK_W'(DOWN_WINDOWS);

  logic                window_end;
  logic [ACT_W-1:0]    act_total;
  power_mode_e         mode, next_mode;
  logic [STREAK_W-1:0] streak, next_streak, streak_inc;
  logic                mode_change;

  activity_window_counter #(.WINDOW(WINDOW)) u_awc (
    .Clk        (Clk),
    .Rst        (Rst),
    .alu_valid  (bus.Alu_Valid),
    .window_end (window_end),
    .act_total  (act_total)
  );

  assign streak_inc = streak + 1'b1;

  always_comb begin
    next_mode   = mode;
    next_streak = streak;
    if (window_end) begin
      if (act_total >= HI_T) begin
        next_mode   = MODE_FULL;
        next_streak = '0;
      end else if (act_total < LO_T) begin
        if (streak_inc == DW_T) begin
          next_streak = '0;
          next_mode   = step_down(mode);
        end else begin
          next_streak = streak_inc;
        end
      end else begin
        next_streak = '0;
      end
    end
    if (bus.Force_Full) begin
      next_mode   = MODE_FULL;
      next_streak = '0;
    end
    // An illegal register value (2'b11) recovers to FULL regardless of inputs.
    case (mode)
      MODE_FULL, MODE_HALF, MODE_QUARTER: ;
      default: begin
        next_mode   = MODE_FULL;
        next_streak = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mode        <= MODE_FULL;
      streak      <= '0;
      mode_change <= 1'b0;
    end else begin
      mode        <= next_mode;
      streak      <= next_streak;
      mode_change <= (next_mode != mode);
    end
  end

  assign bus.Power_Mode  = mode;
  assign bus.Mode_Change = mode_change;

endmodule

// File: tb/tb_power_mode_controller.sv
module tb_power_mode_controller;

  localparam int W  = 16;
  localparam int HI = 12;
  localparam int LO = 4;
  localparam int DW = 2;

  logic Clk = 1'b0;
  logic Rst;
  power_mode_controller_if bus ();

  power_mode_controller #(
    .WINDOW(W), .HI_THRESH(HI), .LO_THRESH(LO), .DOWN_WINDOWS(DW)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Reference model: speed level 0 (/4), 1 (/2), 2 (full); level equals the
  // expected Power_Mode value. Position and activity tracked as plain integers.
  int pos = 0, acts = 0, level = 2, streak = 0;
  bit exp_change = 1'b0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pos = 0; acts = 0; level = 2; streak = 0; exp_change = 1'b0;
    end else begin
      int nlevel, total;
      nlevel = level;
      if (pos == W - 1) begin
        total = acts + int'(bus.Alu_Valid);
        if (total >= HI) begin
          nlevel = 2; streak = 0;
        end else if (total < LO) begin
          streak = streak + 1;
          if (streak >= DW) begin
            streak = 0;
            nlevel = (level > 0) ? level - 1 : 0;
          end
        end else begin
          streak = 0;
        end
        pos = 0; acts = 0;
      end else begin
        pos = pos + 1;
        if (bus.Alu_Valid && acts < W) acts = acts + 1;
      end
      if (bus.Force_Full) begin
        nlevel = 2; streak = 0;
      end
      exp_change = (nlevel != level);
      level = nlevel;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    n_assert++;
    if (int'(bus.Power_Mode) != level) begin
      n_fail++;
      $display("FAIL model_mode t=%0t got=%0d exp=%0d", $time, bus.Power_Mode, level);
    end
    n_assert++;
    if (bus.Mode_Change !== exp_change) begin
      n_fail++;
      $display("FAIL model_change t=%0t got=%0d exp=%0d", $time, bus.Mode_Change, exp_change);
    end
    if (bus.Mode_Change === 1'b1) pulses++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input bit av, input bit ff);
    bus.Alu_Valid  = av;
    bus.Force_Full = ff;
    @(negedge Clk);
    #1;
  endtask

  // One aligned window with `cnt` valids in its final cycles; optional
  // Force_Full in the window-end cycle.
  task automatic window(input int cnt, input bit ff_last);
    for (int p = 0; p < W; p++) tick(p >= W - cnt, ff_last && (p == W - 1));
  endtask

  initial begin
    Rst = 1'b1;
    bus.Alu_Valid  = 1'b0;
    bus.Force_Full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      check("reset_mode", int'(bus.Power_Mode), 2);
      check("reset_change", int'(bus.Mode_Change), 0);
    end
    Rst = 1'b0;
    pulses = 0;

    // Idle: FULL -> HALF exactly at the 32nd edge.
    for (int i = 0; i < 31; i++) tick(0, 0);
    check("idle1_before", int'(bus.Power_Mode), 2);
    tick(0, 0);
    check("idle1_mode", int'(bus.Power_Mode), 1);
    check("idle1_pulse_now", int'(bus.Mode_Change), 1);
    check("idle1_pulses", pulses, 1);
    pulses = 0;
    for (int i = 0; i < 32; i++) tick(0, 0);
    check("idle2_mode", int'(bus.Power_Mode), 0);
    check("idle2_pulses", pulses, 1);
    pulses = 0;
    for (int i = 0; i < 32; i++) tick(0, 0);
    check("idle3_mode", int'(bus.Power_Mode), 0);
    check("idle3_pulses", pulses, 0);

    // Exactly HI valids including the window-end cycle.
    pulses = 0;
    window(12, 0);
    check("hi12_mode", int'(bus.Power_Mode), 2);
    check("hi12_pulses", pulses, 1);
    window(0, 0);
    window(0, 0);
    check("back_half", int'(bus.Power_Mode), 1);
    pulses = 0;
    window(11, 0);
    check("hi11_hold", int'(bus.Power_Mode), 1);
    check("hi11_pulses", pulses, 0);

    // Alternating low/mid windows never complete a streak.
    window(16, 0);
    check("full_again", int'(bus.Power_Mode), 2);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      window(0, 0);
      window(8, 0);
    end
    check("alt_mode", int'(bus.Power_Mode), 2);
    check("alt_pulses", pulses, 0);

    // Force_Full on the second low window end restarts the streak.
    pulses = 0;
    window(0, 0);
    window(0, 1);
    check("force_mode", int'(bus.Power_Mode), 2);
    check("force_pulses", pulses, 0);
    window(0, 0);
    check("force_streak1", int'(bus.Power_Mode), 2);
    window(0, 0);
    check("force_streak2", int'(bus.Power_Mode), 1);

    // Randomized windows checked against the model.
    for (int w = 0; w < 40; w++) begin
      int d;
      d = $urandom_range(0, 16);
      for (int p = 0; p < W; p++)
        tick($urandom_range(0, 15) < d, $urandom_range(0, 63) == 0);
    end

    // Drive to QUARTER, then reset asynchronously mid-window.
    for (int i = 0; i < 80; i++) tick(0, 0);
    check("pre_rst_mode", int'(bus.Power_Mode), 0);
    for (int i = 0; i < 5; i++) tick(0, 0);
    #2 Rst = 1'b1;
    #1;
    check("async_rst_mode", int'(bus.Power_Mode), 2);
    check("async_rst_change", int'(bus.Mode_Change), 0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    pulses = 0;
    for (int i = 0; i < 31; i++) tick(0, 0);
    check("post_rst_before", int'(bus.Power_Mode), 2);
    tick(0, 0);
    check("post_rst_step", int'(bus.Power_Mode), 1);
    check("post_rst_pulses", pulses, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/power_mode_controller.md
POWER_MODE_CONTROLLER -- requirements
Module: power_mode_controller

Interface
REQ-001 Parameters SHALL be as listed, one per line: name, default, meaning.
- WINDOW, 16, observation window length in Clk cycles (>=4).
- HI_THRESH, 12, activity count at or above which mode goes to full speed.
- LO_THRESH, 4, activity count below which a window counts as "low".
- DOWN_WINDOWS, 2, consecutive low windows required before stepping down one level.
REQ-002 Ports SHALL be as listed, one per line: name, direction, width, meaning.
- Clk, input, 1, single clock; all state updates on its rising edge.
- Rst, input, 1, asynchronous active-high reset.
- Alu_Valid, input, 1, ALU operation issued this cycle (activity sample).
- Force_Full, input, 1, request immediate full-speed operation.
- Power_Mode, output, 2, registered mode driven to ClockScaler: 2'b00 = divide by 4, 2'b01 = divide by 2, 2'b10 = full speed.
- Mode_Change, output, 1, registered one-cycle pulse in the cycle Power_Mode takes a new value.
REQ-003 The block SHALL reject parameter sets violating LO_THRESH <= HI_THRESH <= WINDOW or DOWN_WINDOWS < 1 at elaboration.

Function
REQ-004 The window counter SHALL count 0..WINDOW-1, increment every cycle and wrap to 0; cycle WINDOW-1 is the window-end cycle.
REQ-005 The activity counter SHALL add 1 per cycle with Alu_Valid=1, saturate at WINDOW, and clear to 0 after each window end.
REQ-006 At window end, act_total SHALL equal the activity counter plus the Alu_Valid of the window-end cycle itself.
REQ-007 The mode FSM SHALL have exactly three states, FULL (2'b10), HALF (2'b01) and QUARTER (2'b00); Power_Mode is the state register.
REQ-008 At window end with act_total >= HI_THRESH, the next state SHALL be FULL from any state, and the low-streak counter SHALL clear.
REQ-009 At window end with act_total < LO_THRESH, the low-streak counter SHALL increment; on reaching DOWN_WINDOWS it SHALL clear and the state SHALL step down one level (FULL->HALF, HALF->QUARTER, QUARTER->QUARTER).
REQ-010 At window end with LO_THRESH <= act_total < HI_THRESH, the state SHALL hold and the low-streak counter SHALL clear.
REQ-011 Force_Full=1 in any cycle SHALL make the next state FULL and clear the low-streak counter; it SHALL take priority over a simultaneous window-end decision, and window and activity counting SHALL continue unaffected.
REQ-012 A new Power_Mode value SHALL appear one cycle after the deciding edge; there SHALL be no other latency.
REQ-013 Mode_Change SHALL be 1 exactly in the cycles where the registered Power_Mode differs from its previous value; a step-down while in QUARTER, or Force_Full while in FULL, SHALL produce no pulse.
REQ-014 Power_Mode SHALL never take the value 2'b11; if it is corrupted to 2'b11, the FSM SHALL recover to FULL on the next edge.

Reset
REQ-015 Rst=1 SHALL asynchronously set Power_Mode=2'b10 and Mode_Change=0, and clear the window, activity and low-streak counters.
REQ-016 Counting after Rst deasserts SHALL restart at window position 0; a reset mid-window SHALL discard that partial window.

Structure
REQ-017 Mode encodings MODE_QUARTER=2'b00, MODE_HALF=2'b01 and MODE_FULL=2'b10 SHALL live in shared package power_pkg, which ClockScaler also uses.
REQ-018 Window and activity counting SHALL be one sub-module, activity_window_counter, outputting window_end and act_total; the FSM and the Mode_Change logic SHALL stay in the top module.
REQ-019 Counter widths SHALL be derived with $clog2 from WINDOW and DOWN_WINDOWS; no hard-coded widths.

Verification (defaults: WINDOW=16, HI_THRESH=12, LO_THRESH=4, DOWN_WINDOWS=2)
REQ-020 Assert Rst for 3 cycles, then release -> Power_Mode=2'b10 and Mode_Change=0 during and after reset, with no pulse.
REQ-021 Alu_Valid=0 for 32 cycles -> Power_Mode becomes 2'b01 one cycle after the 2nd window end, with a single Mode_Change pulse; 32 more idle cycles -> 2'b00 with one pulse; 32 further idle cycles -> stays 2'b00 with no pulse.
REQ-022 From 2'b00, a window with exactly 12 Alu_Valid cycles, including the window-end cycle -> 2'b10 after that window end, with one pulse; a window with 11 valids -> hold.
REQ-023 Alternate windows of 0 and 8 valids -> the low streak never reaches 2, and Power_Mode holds 2'b10 for 128 cycles.
REQ-024 In FULL, with one low window completed, assert Force_Full in the 2nd low window-end cycle -> Power_Mode stays 2'b10 with no pulse, and the streak restarts (2 further low windows are needed before stepping down).
REQ-025 Assert Rst asynchronously mid-window while in 2'b00 -> Power_Mode=2'b10 immediately without a clock edge, and the next window ends 16 cycles after release.
